sram_8x4: RTL and testbench

- Small single-port synchronous static RAM, 8 words x 4 bits by default, with chip-select and write-enable control.
- Used as a local scratch store: the master drives address, data and control, then samples a registered read port.
- One clock domain. Synchronous active-high reset clears the whole array and the output register.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_array.sv | 43 ++++
 rtl/sram_8x4.sv | 67 ++++++
 tb/tb_sram_8x4.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared sizing constants and types for the sram_8x4 scratch RAM
//
// Purpose: default word/address widths, the derived depth, and word/address
// typedefs used by the array and the top level.
// Ports: none (package).
package sram_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - register-file storage with synchronous write/clear and async read index
//
// Purpose: holds 2**P_ADDR_W words; one synchronous write port, a synchronous
// clear of every word, and a combinational read of the word at i_addr.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high clear of all words
//   i_we     in   write strobe (already qualified by chip select)
//   i_addr   in   word address, shared by the write port and the read index
//   i_wdata  in   write data
//   o_rdata  out  word currently stored at i_addr
module sram_array
  import sram_pkg::*;
#(
  parameter int P_DATA_W = DATA_W,
  parameter int P_ADDR_W = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [P_ADDR_W-1:0] i_addr,
  input  logic [P_DATA_W-1:0] i_wdata,
  output logic [P_DATA_W-1:0] o_rdata
);

  localparam int L_DEPTH = 2 ** P_ADDR_W;

  logic [P_DATA_W-1:0] r_mem [L_DEPTH];

  // Clear wins over a write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sram_8x4.sv
// rtl/sram_8x4.sv - single-port synchronous scratch RAM with registered read port
//
// Purpose: decodes chip select / write enable, writes into sram_array, and
// registers read data into dataOut with a one-cycle readValid pulse.
// Ports:
//   clk          in   rising-edge clock for all state
//   rst          in   synchronous active-high reset; clears array, dataOut, readValid
//   chipSelect   in   1 enables a read or write this cycle
//   writeEnable  in   1 = write, 0 = read (while chipSelect=1)
//   address      in   word address
//   dataIn       in   write data
//   dataOut      out  registered read data, held between reads
//   readValid    out  1 for the cycle after a read loaded dataOut
module sram_8x4
  import sram_pkg::*;
#(
  parameter int DATA_W = sram_pkg::DATA_W,
  parameter int ADDR_W = sram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chipSelect,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              readValid
);

  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_data_out;
  logic              r_read_valid;

  assign w_wr = chipSelect & writeEnable;
  assign w_rd = chipSelect & ~writeEnable;

  sram_array #(
    .P_DATA_W (DATA_W),
    .P_ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr),
    .i_addr  (address),
    .i_wdata (dataIn),
    .o_rdata (w_rdata)
  );

  // dataOut only changes on a read; writes and idle cycles hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd;
      if (w_rd) begin
        r_data_out <= w_rdata;
      end
    end
  end

  assign dataOut   = r_data_out;
  assign readValid = r_read_valid;

endmodule

// File: tb/tb_sram_8x4.sv
// tb/tb_sram_8x4.sv - self-checking bench for sram_8x4 against an array model
module tb_sram_8x4;

  logic       clk;
  logic       rst;
  logic       chipSelect;
  logic       writeEnable;
  logic [2:0] address;
  logic [3:0] dataIn;
  logic [3:0] dataOut;
  logic       readValid;

  sram_8x4 dut (
    .clk         (clk),
    .rst         (rst),
    .chipSelect  (chipSelect),
    .writeEnable (writeEnable),
    .address     (address),
    .dataIn      (dataIn),
    .dataOut     (dataOut),
    .readValid   (readValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] m_mem [8];
  logic [3:0] m_out;
  logic       m_valid;
  bit         cmp_en;
  int         n_checks;
  int         n_pass;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then advance the model by the same edge.
  task automatic cycle(input logic r, input logic cs, input logic we,
                       input logic [2:0] a, input logic [3:0] d);
    rst         = r;
    chipSelect  = cs;
    writeEnable = we;
    address     = a;
    dataIn      = d;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
      m_out   = 4'h0;
      m_valid = 1'b0;
    end else if (cs && we) begin
      m_mem[a] = d;
      m_valid  = 1'b0;
    end else if (cs) begin
      m_out   = m_mem[a];
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_dataOut", dataOut, m_out);
      check("model_readValid", {3'b0, readValid}, {3'b0, m_valid});
    end
  end

  logic [3:0] fill_vals [8];
  logic [3:0] rev_exp   [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cmp_en   = 1'b0;
    m_out    = 4'h0;
    m_valid  = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
    fill_vals = '{4'h4, 4'h1, 4'h9, 4'h3, 4'hD, 4'hD, 4'h5, 4'h2};
    rev_exp   = '{4'h2, 4'h5, 4'hD, 4'hD, 4'h3, 4'h9, 4'h1, 4'h4};

    cycle(1, 0, 0, 3'd0, 4'h0);
    cmp_en = 1'b1;
    check("reset_dataOut", dataOut, 4'h0);
    check("reset_readValid", {3'b0, readValid}, 4'h0);

    // Reset clears every word.
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 3'(i), 4'hA);
    cycle(1, 0, 0, 3'd0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 3'(i), 4'h0);
      check("rst_clear_data", dataOut, 4'h0);
      check("rst_clear_valid", {3'b0, readValid}, 4'h1);
    end

    // Fill and read back in reverse order.
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 3'(i), fill_vals[i]);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 3'(7 - i), 4'h0);
      check("fill_readback", dataOut, rev_exp[i]);
    end

    // Write then read the same address on the next cycle.
    cycle(0, 1, 1, 3'd7, 4'h7);
    cycle(0, 1, 0, 3'd7, 4'h0);
    check("wr_rd_a7", dataOut, 4'h7);
    cycle(0, 1, 1, 3'd4, 4'h4);
    cycle(0, 1, 0, 3'd4, 4'h0);
    check("wr_rd_a4", dataOut, 4'h4);
    cycle(0, 1, 1, 3'd5, 4'h7);
    cycle(0, 1, 0, 3'd5, 4'h0);
    check("wr_rd_a5", dataOut, 4'h7);
    cycle(0, 1, 0, 3'd6, 4'h0);
    check("unchanged_a6", dataOut, 4'h5);

    // Deselected write attempts leave memory and dataOut alone.
    cycle(0, 1, 0, 3'd1, 4'h0);
    check("pre_desel_read", dataOut, 4'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 3'd2, 4'hF);
      check("desel_hold", dataOut, 4'h1);
      check("desel_valid", {3'b0, readValid}, 4'h0);
    end
    cycle(0, 1, 0, 3'd2, 4'h0);
    check("desel_mem2", dataOut, 4'h9);

    // A write does not disturb the output register.
    cycle(0, 1, 0, 3'd1, 4'h0);
    check("rd_a1", dataOut, 4'h1);
    cycle(0, 1, 1, 3'd1, 4'hC);
    check("wr_hold_data", dataOut, 4'h1);
    check("wr_hold_valid", {3'b0, readValid}, 4'h0);
    cycle(0, 1, 0, 3'd1, 4'h0);
    check("rd_a1_new", dataOut, 4'hC);

    // Reset in the same cycle as a write drops the write.
    cycle(1, 1, 1, 3'd3, 4'h6);
    check("rst_mid_data", dataOut, 4'h0);
    check("rst_mid_valid", {3'b0, readValid}, 4'h0);
    cycle(0, 1, 0, 3'd3, 4'h0);
    check("rst_mid_a3", dataOut, 4'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
